// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the add/sub issue wrapper and the fsub pipeline.
//   FP32_W / FP_SIGN_BIT : single-precision layout
//   OP_ADD / OP_SUB      : request opcode encoding
//   res_entry_t          : one buffered result {y, ovf, tag}
//   fp_neg()             : sign flip helper used to turn add into subtract
package fpu_pkg;
  localparam int   FP32_W      = 32;
  localparam int   FP_SIGN_BIT = 31;
  localparam logic OP_ADD      = 1'b0;
  localparam logic OP_SUB      = 1'b1;
  // Widest tag a result entry can carry; narrower tags are zero-extended.
  localparam int   RES_TAG_W   = 8;

  typedef struct packed {
    logic [FP32_W-1:0]    y;
    logic                 ovf;
    logic [RES_TAG_W-1:0] tag;
  } res_entry_t;

  function automatic logic [FP32_W-1:0] fp_neg(input logic [FP32_W-1:0] x);
    return {~x[FP_SIGN_BIT], x[FP_SIGN_BIT-1:0]};
  endfunction
endpackage

// File: rtl/fsub.sv
// Fixed-latency FP32 subtract, y = x1 - x2, round-to-nearest-even.
// No stall, no valid: samples x1/x2 every edge, result stable NSTAGE edges later.
//   clk    : clock
//   x1, x2 : IEEE-754 single operands
//   y      : difference
//   ovf    : finite operands produced a result too large to represent (y = inf)
module fsub
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 2
) (
  input  logic              clk,
  input  logic [FP32_W-1:0] x1,
  input  logic [FP32_W-1:0] x2,
  output logic [FP32_W-1:0] y,
  output logic              ovf
);
  logic [31:0] ua, ub, a, b, yc;
  logic        ovfc, nan_a, nan_b, inf_a, inf_b, rnd;
  logic [7:0]  ea, eb, d;
  logic [26:0] ma, mb, mbs;
  logic [27:0] s;
  logic [9:0]  e;
  logic [24:0] mr;

  assign ua = x1;
  assign ub = fp_neg(x2);

  always_comb begin
    // Order by magnitude so the shift is always applied to b.
    if (ua[30:0] < ub[30:0]) begin a = ub; b = ua; end
    else                     begin a = ua; b = ub; end
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // Denormals use exponent 1 with no hidden bit; 3 guard bits below the LSB.
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {a[30:23] != 8'd0, a[22:0], 3'b000};
    mb = {b[30:23] != 8'd0, b[22:0], 3'b000};
    d  = ea - eb;
    if (d > 8'd26) mbs = {26'd0, |mb};
    else           mbs = (mb >> d) | {26'd0, |(mb & ((27'd1 << d) - 27'd1))};
    if (a[31] ^ b[31]) s = {1'b0, ma} - {1'b0, mbs};
    else               s = {1'b0, ma} + {1'b0, mbs};
    e = {2'b00, ea};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    // Left-normalise, stopping at exponent 1 so tiny results stay denormal.
    for (int i = 0; i < 26; i++)
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    mr  = {1'b0, s[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = {1'b0, 24'h800000};
      e  = e + 10'd1;
    end
    ovfc = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (a[31] ^ b[31]))) yc = 32'h7FC00000;
    else if (inf_a)           yc = a;  // inf always sorts into a
    else if (e >= 10'd255) begin
      yc   = {a[31], 8'hFF, 23'd0};
      ovfc = 1'b1;
    end
    else if (mr[23:0] == 24'd0) yc = {a[31] & b[31], 31'd0};
    else yc = {a[31], mr[23] ? e[7:0] : 8'd0, mr[22:0]};
  end

  logic [NSTAGE-1:0][32:0] pipe_q;
  always_ff @(posedge clk) begin
    pipe_q[0] <= {yc, ovfc};
    for (int i = 1; i < NSTAGE; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign y   = pipe_q[NSTAGE-1][32:1];
  assign ovf = pipe_q[NSTAGE-1][0];
endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/collect wrapper around the fsub pipeline.
// Requests (valid/ready) are fed straight into fsub, add becoming subtract by
// flipping the sign of x2. A {valid, tag} delay line matched to the fsub latency
// captures each result into a DEPTH-entry FIFO. Because fsub cannot stall, a
// credit counter only admits a request when a FIFO slot is reserved for it.
//   clk, rstn                 : clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_op, req_x1/x2, req_tag: 0=add 1=sub, operands, opaque tag
//   res_valid/res_ready       : result handshake (FIFO head)
//   res_y, res_ovf, res_tag   : result, fsub overflow flag, tag
//   busy                      : any operation in flight or buffered
module fpu_addsub_issue
  import fpu_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [FP32_W-1:0] req_x1,
  input  logic [FP32_W-1:0] req_x2,
  input  logic [TAGW-1:0]   req_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP32_W-1:0] res_y,
  output logic              res_ovf,
  output logic [TAGW-1:0]   res_tag,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    accept, pop, push;
  logic [FP32_W-1:0]       fs_x2, fs_y;
  logic                    fs_ovf;
  logic [LAT-1:0]          vld_pipe_q;
  logic [LAT-1:0][TAGW-1:0] tag_pipe_q;
  logic [CW-1:0]           cnt_q, cnt_d, occ_q, occ_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  res_entry_t              mem_q [DEPTH];
  res_entry_t              wr_entry, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready comes from registered credit only; a pop frees the slot next cycle.
  assign req_ready = (cnt_q < CW'(DEPTH));
  assign busy      = (cnt_q != '0);
  assign res_valid = (occ_q != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = res_valid && res_ready;
  assign push      = vld_pipe_q[LAT-1];

  // fsub computes x1 - x2, so an add presents -x2.
  assign fs_x2 = (req_op == OP_SUB) ? req_x2 : fp_neg(req_x2);

  fsub #(.NSTAGE(LAT)) u_fsub (
    .clk (clk),
    .x1  (req_x1),
    .x2  (fs_x2),
    .y   (fs_y),
    .ovf (fs_ovf)
  );

  assign wr_entry = '{y: fs_y, ovf: fs_ovf, tag: RES_TAG_W'(tag_pipe_q[LAT-1])};
  assign head     = mem_q[rd_ptr_q];
  assign res_y    = head.y;
  assign res_ovf  = head.ovf;
  assign res_tag  = TAGW'(head.tag);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
    occ_d = occ_q;
    if (push && !pop)        occ_d = occ_q + CW'(1);
    else if (!push && pop)   occ_d = occ_q - CW'(1);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_pipe_q[0] <= accept;
      for (int i = 1; i < LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data path: tags and storage need no reset, valid bits gate them.
  always_ff @(posedge clk) begin
    tag_pipe_q[0] <= req_tag;
    for (int i = 1; i < LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

// File: tb/tb_fpu_addsub_issue.sv
module tb_fpu_addsub_issue;
  import fpu_pkg::*;
  localparam int LAT = 2, DEPTH = 4, TAGW = 5;

  logic            clk = 1'b0, rstn = 1'b0;
  logic            req_valid = 1'b0, req_op = 1'b0, res_ready = 1'b0;
  logic [31:0]     req_x1 = '0, req_x2 = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            req_ready, res_valid, res_ovf, busy;
  logic [31:0]     res_y;
  logic [TAGW-1:0] res_tag;

  fpu_addsub_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_ovf(res_ovf), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] y; logic ovf; logic [TAGW-1:0] tag; } exp_t;
  typedef struct { logic op; logic [31:0] x1; logic [31:0] x2; logic [31:0] y; logic ovf; } vec_t;

  exp_t        sb[$];
  exp_t        eh;
  vec_t        vt[8];
  logic [31:0] exp_y = '0;
  logic        exp_ovf = 1'b0;
  int          checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: push expected on request handshake, compare on result handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: actual tag=%0d required none", res_tag);
        end else begin
          eh = sb.pop_front();
          chk("res_y", res_y, eh.y);
          chk("res_ovf", 32'(res_ovf), 32'(eh.ovf));
          chk("res_tag", 32'(res_tag), 32'(eh.tag));
        end
      end
      if (req_valid && req_ready) sb.push_back('{exp_y, exp_ovf, req_tag});
      checks++;
      if (dut.occ_q == 3'(DEPTH) && dut.push && !dut.pop) begin
        failures++;
        $display("FAIL fifo_overflow: actual push into full FIFO required none");
      end
    end
  end

  task automatic send(input logic op, input logic [31:0] x1, input logic [31:0] x2,
                      input logic [TAGW-1:0] tag, input logic [31:0] ey, input logic eo,
                      output int waits);
    bit ok;
    ok = 1'b0; waits = 0;
    req_op = op; req_x1 = x1; req_x2 = x2; req_tag = tag;
    exp_y = ey; exp_ovf = eo; req_valid = 1'b1;
    while (!ok && waits < 50) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; waits++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: actual no accept required accept tag=%0d", tag);
    end
  endtask

  task automatic drain();
    int n;
    n = 0; res_ready = 1'b1;
    while ((sb.size() != 0 || res_valid) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_idle", 32'(res_valid), 32'd0);
  endtask

  task automatic lat_check(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!res_valid && k < 10);
    chk(name, 32'(k), 32'd3);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1);
  end

  initial begin
    int w;
    vt[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0}; // 1+2
    vt[1] = '{OP_SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0}; // 3-1
    vt[2] = '{OP_ADD, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0}; // 1+(-1)
    vt[3] = '{OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1}; // max+max
    vt[4] = '{OP_SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0}; // 1-1
    vt[5] = '{OP_ADD, 32'h3FC00000, 32'h3F000000, 32'h40000000, 1'b0}; // 1.5+0.5
    vt[6] = '{OP_SUB, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0}; // 1-2
    vt[7] = '{OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0}; // inf+1

    // reset state
    rstn = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // isolated ops: value via scoreboard, latency counted here
    for (int i = 0; i < 8; i++) begin
      send(vt[i].op, vt[i].x1, vt[i].x2, TAGW'(i + 1), vt[i].y, vt[i].ovf, w);
      req_valid = 1'b0;
      lat_check("latency");
    end
    drain();

    // back-to-back stream never stalls while res_ready=1
    for (int i = 0; i < 8; i++) begin
      send(vt[i].op, vt[i].x1, vt[i].x2, TAGW'(i + 16), vt[i].y, vt[i].ovf, w);
      chk("stream_no_stall", 32'(w), 32'd1);
    end
    req_valid = 1'b0;
    drain();

    // backpressure: only DEPTH accepted, head held stable
    res_ready = 1'b0;
    for (int t = 0; t < 4; t++)
      send(OP_ADD, 32'h3F800000, 32'h40000000, TAGW'(t), 32'h40400000, 1'b0, w);
    req_tag = TAGW'(4);
    repeat (6) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_tag", 32'(res_tag), 32'd0);
      chk("bp_hold_y", res_y, 32'h40400000);
    end
    res_ready = 1'b1;
    send(OP_ADD, 32'h3F800000, 32'h40000000, TAGW'(4), 32'h40400000, 1'b0, w);
    send(OP_ADD, 32'h3F800000, 32'h40000000, TAGW'(5), 32'h40400000, 1'b0, w);
    req_valid = 1'b0;
    drain();
    chk("bp_busy_end", 32'(busy), 32'd0);

    // push and pop on the same edge with cnt=DEPTH
    res_ready = 1'b0;
    for (int t = 10; t < 13; t++)
      send(OP_SUB, 32'h40400000, 32'h3F800000, TAGW'(t), 32'h40000000, 1'b0, w);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("fc_occ_before", 32'(dut.occ_q), 32'd3);
    send(OP_SUB, 32'h40400000, 32'h3F800000, TAGW'(13), 32'h40000000, 1'b0, w);
    req_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("fc_push_pop", 32'({dut.push, dut.pop}), 32'd3);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("fc_occ_after", 32'(dut.occ_q), 32'd3);
    chk("fc_head_tag", 32'(res_tag), 32'd11);
    chk("fc_req_ready", 32'(req_ready), 32'd1);
    drain();

    // reset while ops are in flight
    res_ready = 1'b1;
    for (int t = 20; t < 23; t++)
      send(OP_ADD, 32'h3F800000, 32'h40000000, TAGW'(t), 32'h40400000, 1'b0, w);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sb.delete();
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cnt", 32'(dut.cnt_q), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("mr_res_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(OP_SUB, 32'h40400000, 32'h3F800000, TAGW'(25), 32'h40000000, 1'b0, w);
    req_valid = 1'b0;
    lat_check("mr_latency");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_addsub_issue.md
Name: fpu_addsub_issue

Overview:
- Issue/collect wrapper that sits directly around the fixed-latency fsub pipeline and feeds it. It owns the fsub instance.
- Accepts add/sub requests over a valid/ready handshake and converts add into subtract by flipping the sign of x2.
- Tracks valid and tag through a delay line matched to the fsub latency, then captures each result into a small output FIFO.
- The fsub pipeline cannot stall, so a credit counter guarantees every accepted operation has a free FIFO slot before it is issued.

Parameters:
- LAT, 2, fsub latency in edges from operand sample to stable y; must equal the fsub NSTAGE.
- DEPTH, 4, result FIFO entries; also the maximum number of outstanding operations (in flight plus buffered).
- TAGW, 5, width of the request/result tag (destination register id).

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid&&req_ready at a rising edge
- req_op  input  1  0 = add (x1+x2), 1 = sub (x1-x2)
- req_x1  input  32  IEEE-754 single operand 1
- req_x2  input  32  IEEE-754 single operand 2
- req_tag  input  TAGW  opaque tag, returned with the result
- res_valid  output  1  FIFO head valid
- res_ready  input  1  consumer pops when res_valid&&res_ready at a rising edge
- res_y  output  32  result
- res_ovf  output  1  fsub ovf flag for this result
- res_tag  output  TAGW  tag of this result
- busy  output  1  high when cnt != 0

Behaviour:
- Reset: synchronous on rstn=0.
  - Clears the delay line, FIFO pointers and cnt.
  - After reset: req_ready=1, res_valid=0, busy=0. res_y, res_ovf and res_tag are don't-care while res_valid=0.
  - Reset mid-operation drops all in-flight and buffered results silently. No result from before reset may appear afterwards.
- fsub feed (combinational, no extra register):
  - x1 = req_x1.
  - x2 = req_op ? req_x2 : {~req_x2[31], req_x2[30:0]}.
  - fsub samples every cycle. Non-accepted cycles produce garbage that is ignored.
- Timing:
  - An operation is accepted in cycle C0 (handshake at the end-of-C0 edge).
  - fsub y is stable in cycle C0+LAT.
  - The result is pushed into the FIFO at the end of C0+LAT.
  - Earliest res_valid is in C0+LAT+1 (3 cycles for LAT=2). There is no bypass.
- Delay line: LAT stages of {valid, tag}.
  - Stage 0 loads {accept, req_tag} every edge.
  - Stage LAT-1 with valid=1 pushes {fsub.y, fsub.ovf, tag} into the FIFO at the next edge.
- Credit counter cnt (0..DEPTH, width clog2(DEPTH+1)):
  - +1 on accept, -1 on pop. Accept and pop in the same edge leave cnt unchanged.
  - req_ready = (cnt < DEPTH). It depends on registered state only, with no combinational path from res_ready.
  - A pop in cycle C frees a slot visible to req_ready from C+1.
- FIFO:
  - Circular buffer with DEPTH entries, pointer wrap at DEPTH (DEPTH need not be a power of two), plus an occupancy count.
  - Push and pop in the same edge are legal, including when the FIFO is full.
  - Push into a full FIFO without a simultaneous pop is impossible by construction; the bench asserts this never happens.
  - Pop when empty is ignored.
- Ordering: results emerge strictly in acceptance order.
- Throughput: 1 op/cycle sustained while res_ready=1.
- Output stability: while res_valid=1 and res_ready=0, res_y, res_ovf and res_tag are held constant.
- Special values: inf/NaN/ovf semantics are whatever fsub produces. This block does not alter them.

Decomposition:
- Shared package fpu_pkg:
  - FP32_W=32, FP_SIGN_BIT=31.
  - Op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
  - Typedef of the result entry {y[31:0], ovf, tag}.
- One sub-module, instantiated here: fsub (existing, NSTAGE=LAT).
- The FIFO stays inline; it is too small to justify a separate module.

Test Plan:
- Single add: x1=0x3F800000, x2=0x40000000, op=0, tag=3, res_ready=1 -> res_valid exactly 3 cycles after the handshake cycle, res_y=0x40400000, res_ovf=0, res_tag=3.
- Single sub: x1=0x40400000, x2=0x3F800000, op=1 -> 0x40000000. Sign handling: x1=0x3F800000, x2=0xBF800000, op=0 -> 0x00000000.
- Overflow: x1=x2=0x7F7FFFFF, op=0 -> res_y=0x7F800000, res_ovf=1.
- Backpressure:
  - Setup: res_ready=0, req_valid held high with tags 0..5.
  - Exactly 4 accepted; req_ready=0 from the cycle after the 4th accept; busy=1; outputs held stable.
  - Raise res_ready -> tags 0..5 are delivered in order with no loss or duplication.
- Full concurrency: with cnt=DEPTH and the FIFO full, pop in the same cycle a push arrives -> no overflow, occupancy unchanged, order preserved.
- Reset mid-operation:
  - Accept 3 ops, then assert rstn=0 for 1 cycle during flight.
  - res_valid stays 0 for 5 cycles after reset.
  - cnt=0, req_ready=1.
  - A new op afterwards returns the correct result with 3-cycle latency.
